// File: rtl/pipe_skid_buffer_if.sv
// Valid/ready/data handshake bundle for one side of the skid buffer.
// The master drives valid and data, and the slave drives ready.
interface pipe_skid_buffer_if #(
   parameter int WIDTH = 8
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_buffer.sv
// Two-entry registered skid buffer between pipeline stages, with a synchronous flush.
// Handshake outputs come only from the state register, so a consumer stall cannot reach the producer combinationally.
module pipe_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   pipe_skid_buffer_if.slave  inBus,
   pipe_skid_buffer_if.master outBus,
   output logic [1:0]        count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stateT;

   stateT            state;
   stateT            stateNext;
   logic [WIDTH-1:0] mainReg;
   logic [WIDTH-1:0] skidReg;
   logic             inXfer;
   logic             outXfer;
   logic             loadMainIn;
   logic             loadMainSkid;
   logic             loadSkid;

   // The state encoding doubles as the occupancy count.
   assign inBus.ready  = (state != FULL);
   assign outBus.valid = (state != EMPTY);
   assign outBus.data  = mainReg;
   assign count        = state;

   assign inXfer  = inBus.valid && inBus.ready;
   assign outXfer = outBus.valid && outBus.ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= EMPTY;
      end else begin
         state <= stateNext;
      end
   end

   // Flush wins over everything and discards a word accepted in the same cycle.
   always_comb begin
      stateNext    = state;
      loadMainIn   = 1'b0;
      loadMainSkid = 1'b0;
      loadSkid     = 1'b0;
      if (flush) begin
         stateNext = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (inXfer) begin
                  loadMainIn = 1'b1;
                  stateNext  = ONE;
               end
            end
            ONE: begin
               if (inXfer && outXfer) begin
                  loadMainIn = 1'b1;
               end else if (inXfer) begin
                  loadSkid  = 1'b1;
                  stateNext = FULL;
               end else if (outXfer) begin
                  stateNext = EMPTY;
               end
            end
            FULL: begin
               if (outXfer) begin
                  loadMainSkid = 1'b1;
                  stateNext    = ONE;
               end
            end
            default: stateNext = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mainReg <= '0;
         skidReg <= '0;
      end else begin
         if (loadMainIn) begin
            mainReg <= inBus.data;
         end else if (loadMainSkid) begin
            mainReg <= skidReg;
         end
         if (loadSkid) begin
            skidReg <= inBus.data;
         end
      end
   end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed and randomized checks of pipe_skid_buffer against hand-computed values and a queue model.
module tb_pipe_skid_buffer;

   logic       clk;
   logic       reset_n;
   logic       flush;
   logic [1:0] count;
   int         checks;
   int         errors;

   pipe_skid_buffer_if #(.WIDTH(8)) inBus ();
   pipe_skid_buffer_if #(.WIDTH(8)) outBus ();

   pipe_skid_buffer #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .inBus   (inBus),
      .outBus  (outBus),
      .count   (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
      inBus.valid  = iv;
      inBus.data   = id;
      outBus.ready = ordy;
      flush        = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkStatus(input string tag, input logic expValid, input logic expReady, input logic [1:0] expCount);
      checkOutput({tag, ".out_valid"}, 32'(outBus.valid), 32'(expValid));
      checkOutput({tag, ".in_ready"}, 32'(inBus.ready), 32'(expReady));
      checkOutput({tag, ".count"}, 32'(count), 32'(expCount));
   endtask

   task automatic checkData(input string tag, input logic [7:0] expData);
      checkOutput({tag, ".out_data"}, 32'(outBus.data), 32'(expData));
   endtask

   initial begin
      logic [7:0] q[$];
      logic       it;
      logic       ot;
      logic       iv;
      logic       ordy;
      logic       fl;
      logic       held;
      logic [7:0] id;
      logic [7:0] heldData;

      checks = 0;
      errors = 0;
      reset_n = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      #1 reset_n = 1'b0;
      #2;
      checkStatus("reset", 1'b0, 1'b1, 2'd0);
      checkData("reset", 8'h00);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      checkStatus("idle", 1'b0, 1'b1, 2'd0);

      // Streaming at full rate.
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
         tick();
         checkStatus("stream", 1'b1, 1'b1, 2'd1);
         checkData("stream", 8'(i));
      end
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      checkStatus("streamDrain", 1'b0, 1'b1, 2'd0);

      // Backpressure.
      applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
      tick();
      checkStatus("bp1", 1'b1, 1'b1, 2'd1);
      checkData("bp1", 8'hA5);
      applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
      tick();
      checkStatus("bp2", 1'b1, 1'b0, 2'd2);
      checkData("bp2", 8'hA5);
      applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
      tick();
      tick();
      checkStatus("bpHold", 1'b1, 1'b0, 2'd2);
      checkData("bpHold", 8'hA5);
      applyStimulus(1'b1, 8'hC3, 1'b1, 1'b0);
      tick();
      checkStatus("bpPop1", 1'b1, 1'b1, 2'd1);
      checkData("bpPop1", 8'h5A);
      tick();
      checkStatus("bpPop2", 1'b1, 1'b1, 2'd1);
      checkData("bpPop2", 8'hC3);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      checkStatus("bpDrain", 1'b0, 1'b1, 2'd0);

      // Simultaneous input and output transfers in ONE.
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
      tick();
      checkData("sim1", 8'h11);
      applyStimulus(1'b1, 8'h22, 1'b1, 1'b0);
      tick();
      checkStatus("simBoth", 1'b1, 1'b1, 2'd1);
      checkData("simBoth", 8'h22);
      applyStimulus(1'b1, 8'h66, 1'b0, 1'b0);
      tick();
      checkStatus("simInOnly", 1'b1, 1'b0, 2'd2);
      checkData("simInOnly", 8'h22);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      checkData("simDrain1", 8'h66);
      tick();
      checkStatus("simDrain2", 1'b0, 1'b1, 2'd0);

      // Flush from FULL with a word presented in the flush cycle.
      applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
      tick();
      checkStatus("preFlush", 1'b1, 1'b0, 2'd2);
      applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
      tick();
      checkStatus("flush", 1'b0, 1'b1, 2'd0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      tick();
      checkStatus("postFlush", 1'b0, 1'b1, 2'd0);

      // Asynchronous reset while FULL.
      applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 8'h88, 1'b0, 1'b0);
      tick();
      checkStatus("preReset", 1'b1, 1'b0, 2'd2);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkStatus("midReset", 1'b0, 1'b1, 2'd0);
      checkData("midReset", 8'h00);
      tick();
      checkStatus("heldReset", 1'b0, 1'b1, 2'd0);
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
      #1;
      checkStatus("released", 1'b0, 1'b1, 2'd0);
      tick();
      checkStatus("firstAfterReset", 1'b1, 1'b1, 2'd1);
      checkData("firstAfterReset", 8'h99);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      checkStatus("resetDrain", 1'b0, 1'b1, 2'd0);

      // Random traffic against a queue model.
      q.delete();
      for (int n = 0; n < 300; n++) begin
         iv   = 1'($urandom_range(0, 1));
         ordy = 1'($urandom_range(0, 1));
         fl   = ($urandom_range(0, 15) == 0);
         id   = 8'($urandom);
         applyStimulus(iv, id, ordy, fl);
         it       = iv && (q.size() < 2);
         ot       = (q.size() > 0) && ordy;
         held     = (q.size() > 0) && !ordy && !fl;
         heldData = (q.size() > 0) ? q[0] : 8'h00;
         tick();
         if (fl) begin
            q.delete();
         end else begin
            if (ot) void'(q.pop_front());
            if (it) q.push_back(id);
         end
         checkStatus("rand", q.size() != 0, q.size() != 2, 2'(q.size()));
         if (q.size() > 0) checkData("randOrder", q[0]);
         if (held) checkData("randStable", heldData);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
